// File: rtl/serial_word_receiver.sv
// Serial-to-parallel word receiver with MSB/LSB-first order and a one-entry output buffer.
// Optional trailing parity bit: define SERIAL_RX_PARITY_EN.
module serial_word_receiver #(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             dir,
    input  logic             s_din,
    input  logic             s_din_valid,
    output logic [WIDTH-1:0] p_dout,
    output logic             p_dout_valid,
    input  logic             p_dout_ready,
    output logic             busy,
    output logic             overrun,
    output logic             parity_err
);

    localparam int CW = $clog2(WIDTH);
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    typedef enum logic [1:0] {
        IDLE,
        RECV
`ifdef SERIAL_RX_PARITY_EN
        , PAR
`endif
    } state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] sh_q, sh_d, sh_next;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic             dir_q, dir_d;
    logic [WIDTH-1:0] dout_q, dout_d;
    logic             valid_q, valid_d;
    logic             ovr_q, ovr_d;
    logic             buf_free;
`ifdef SERIAL_RX_PARITY_EN
    logic             perr_q, perr_d;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            sh_q    <= '0;
            cnt_q   <= '0;
            dir_q   <= 1'b0;
            dout_q  <= '0;
            valid_q <= 1'b0;
            ovr_q   <= 1'b0;
`ifdef SERIAL_RX_PARITY_EN
            perr_q  <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            sh_q    <= sh_d;
            cnt_q   <= cnt_d;
            dir_q   <= dir_d;
            dout_q  <= dout_d;
            valid_q <= valid_d;
            ovr_q   <= ovr_d;
`ifdef SERIAL_RX_PARITY_EN
            perr_q  <= perr_d;
`endif
        end
    end

    always_comb begin
        state_d  = state_q;
        sh_d     = sh_q;
        cnt_d    = cnt_q;
        dir_d    = dir_q;
        dout_d   = dout_q;
        valid_d  = valid_q & ~p_dout_ready;
        ovr_d    = ovr_q;
`ifdef SERIAL_RX_PARITY_EN
        perr_d   = perr_q;
`endif
        // A word may load on the same edge the consumer drains the buffer
        buf_free = ~valid_q | p_dout_ready;
        sh_next  = dir_q ? {s_din, sh_q[WIDTH-1:1]}
                         : {sh_q[WIDTH-2:0], s_din};
        unique case (state_q)
            IDLE: begin
                if (start) begin
                    dir_d   = dir;
                    cnt_d   = '0;
                    ovr_d   = 1'b0;
                    state_d = RECV;
                end
            end
            RECV: begin
                if (s_din_valid) begin
                    sh_d  = sh_next;
                    cnt_d = cnt_q + CW'(1);
                    if (cnt_q == LAST) begin
`ifdef SERIAL_RX_PARITY_EN
                        state_d = PAR;
`else
                        state_d = IDLE;
                        if (buf_free) begin
                            dout_d  = sh_next;
                            valid_d = 1'b1;
                        end else begin
                            ovr_d = 1'b1;
                        end
`endif
                    end
                end
            end
`ifdef SERIAL_RX_PARITY_EN
            PAR: begin
                if (s_din_valid) begin
                    state_d = IDLE;
                    if (buf_free) begin
                        dout_d  = sh_q;
                        valid_d = 1'b1;
                        // Set when even parity over data plus parity bit fails
                        perr_d  = ^{sh_q, s_din};
                    end else begin
                        ovr_d = 1'b1;
                    end
                end
            end
`endif
            default: state_d = IDLE;
        endcase
    end

    assign p_dout       = dout_q;
    assign p_dout_valid = valid_q;
    assign overrun      = ovr_q;
    assign busy         = (state_q != IDLE);
`ifdef SERIAL_RX_PARITY_EN
    assign parity_err   = perr_q;
`else
    assign parity_err   = 1'b0;
`endif

endmodule

// File: tb/tb_serial_word_receiver.sv
// Bench for serial_word_receiver: directed frames plus random frames vs a word-level model.
// Honours SERIAL_RX_PARITY_EN when defined for the whole build.
module tb_serial_word_receiver;
  localparam int W = 4;
`ifdef SERIAL_RX_PARITY_EN
  localparam int NB = W + 1;
`else
  localparam int NB = W;
`endif

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         start = 1'b0;
  logic         dir = 1'b0;
  logic         s_din = 1'b0;
  logic         s_din_valid = 1'b0;
  logic [W-1:0] p_dout;
  logic         p_dout_valid;
  logic         p_dout_ready = 1'b0;
  logic         busy;
  logic         overrun;
  logic         parity_err;

  int tests = 0;
  int fails = 0;

  logic [W-1:0] m_dout = '0;
  logic         m_valid = 1'b0;
  logic         m_ovr = 1'b0;
  logic         m_perr = 1'b0;

  serial_word_receiver #(.WIDTH(W)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .start        (start),
    .dir          (dir),
    .s_din        (s_din),
    .s_din_valid  (s_din_valid),
    .p_dout       (p_dout),
    .p_dout_valid (p_dout_valid),
    .p_dout_ready (p_dout_ready),
    .busy         (busy),
    .overrun      (overrun),
    .parity_err   (parity_err)
  );

  always #5 clk = ~clk;

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag,
                     input logic [W-1:0] obs,
                     input logic [W-1:0] exp);
    tests++;
    if (obs !== exp) begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h",
             tag, obs, exp);
    end
  endtask

  task automatic check_out(input string tag,
                           input logic exp_busy);
    chk({tag, "/valid"}, W'(p_dout_valid), W'(m_valid));
    chk({tag, "/dout"}, p_dout, m_dout);
    chk({tag, "/overrun"}, W'(overrun), W'(m_ovr));
    chk({tag, "/parity_err"}, W'(parity_err), W'(m_perr));
    chk({tag, "/busy"}, W'(busy), W'(exp_busy));
  endtask

  task automatic wait_valid(input string tag, input int limit);
    int k;
    k = 0;
    while (p_dout_valid !== 1'b1 && k < limit) begin
      tick;
      k++;
    end
    tests++;
    if (p_dout_valid !== 1'b1) begin
      fails++;
      $error("FAIL %s: p_dout_valid not seen within %0d cycles",
             tag, limit);
    end
  endtask

  task automatic frame(input logic d, input logic [W-1:0] word,
                       input logic pbit, input int gap,
                       input logic rdy_end, input logic rnd_start);
    start = 1'b1;
    dir = d;
    s_din_valid = 1'b0;
    p_dout_ready = 1'b0;
    tick;
    m_ovr = 1'b0;
    start = 1'b0;
    dir = 1'($urandom);
    check_out("frame_start", 1'b1);
    for (int i = 0; i < NB; i++) begin
      for (int g = 0; g < gap; g++) begin
        s_din_valid = 1'b0;
        s_din = 1'($urandom);
        if (rnd_start) start = 1'($urandom);
        tick;
        check_out("gap", 1'b1);
      end
      s_din_valid = 1'b1;
      if (i >= W) s_din = pbit;
      else if (d) s_din = word[i];
      else s_din = word[W-1-i];
      if (rnd_start) start = 1'($urandom);
      if (i == NB - 1) p_dout_ready = rdy_end;
      tick;
      if (i < NB - 1) check_out("bit", 1'b1);
    end
    s_din_valid = 1'b0;
    p_dout_ready = 1'b0;
    start = 1'b0;
    if (!m_valid || rdy_end) begin
      m_valid = 1'b1;
      m_dout = word;
`ifdef SERIAL_RX_PARITY_EN
      m_perr = ^{word, pbit};
`endif
    end else begin
      m_ovr = 1'b1;
    end
    check_out("frame_done", 1'b0);
  endtask

  task automatic drain;
    p_dout_ready = 1'b1;
    tick;
    p_dout_ready = 1'b0;
    m_valid = 1'b0;
    check_out("drain", 1'b0);
  endtask

  initial begin
    #1;
    tests++;
    if (p_dout !== '0 || p_dout_valid !== 1'b0 ||
        busy !== 1'b0 || overrun !== 1'b0 ||
        parity_err !== 1'b0) begin
      fails++;
      $error("FAIL reset_state: dout %0h valid %0b busy %0b ovr %0b perr %0b",
             p_dout, p_dout_valid, busy, overrun, parity_err);
    end
    check_out("reset", 1'b0);
    tick;
    tick;
    #2 rst_n = 1'b1;
    tick;
    check_out("post_reset", 1'b0);

    frame(1'b0, 4'b1101, 1'b1, 0, 1'b0, 1'b0);
    drain;
    frame(1'b1, 4'b1101, 1'b0, 0, 1'b0, 1'b0);
    drain;
    frame(1'b0, 4'b1010, 1'b0, 2, 1'b0, 1'b0);
    drain;

    frame(1'b0, 4'b1101, 1'b1, 0, 1'b0, 1'b0);
    frame(1'b0, 4'b0011, 1'b0, 0, 1'b0, 1'b0);
    drain;
    frame(1'b1, 4'b0101, 1'b0, 1, 1'b0, 1'b0);
    frame(1'b0, 4'b1110, 1'b1, 0, 1'b1, 1'b0);
    drain;

    start = 1'b1;
    dir = 1'b0;
    tick;
    start = 1'b0;
    s_din_valid = 1'b1;
    s_din = 1'b1;
    tick;
    tick;
    s_din_valid = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    m_dout = '0;
    m_valid = 1'b0;
    m_ovr = 1'b0;
    m_perr = 1'b0;
    check_out("abort_reset", 1'b0);
    @(posedge clk);
    #2 rst_n = 1'b1;
    check_out("abort_release", 1'b0);
    frame(1'b0, 4'b0110, 1'b0, 0, 1'b0, 1'b0);
    wait_valid("abort_frame_valid", 4);

    for (int n = 0; n < 4; n++) begin
      s_din_valid = 1'b1;
      s_din = 1'($urandom);
      tick;
      check_out("idle_noise", 1'b0);
    end
    s_din_valid = 1'b0;
    drain;

    for (int n = 0; n < 40; n++) begin
      frame(1'($urandom), W'($urandom), 1'($urandom),
            int'($urandom_range(0, 2)), 1'($urandom), 1'b1);
      if ($urandom_range(0, 1) == 1) drain;
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
